// File: rtl/clock_display_pkg.sv
// Shared constants for the clock display path: active-low segment codes,
// anode patterns and the digit-slot indices used by the scanner.
package clock_display_pkg;

   // Segment codes are {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   localparam logic [3:0] AN_OFF   = 4'hF;

   localparam logic [1:0] IDX_S2   = 2'd0;
   localparam logic [1:0] IDX_S1   = 2'd1;
   localparam logic [1:0] IDX_M2   = 2'd2;
   localparam logic [1:0] IDX_M1   = 2'd3;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment decoder; values above 9
// show a dash so corrupt counter values are visible on the display.
module bcd_to_seg
   import clock_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes the four clock digits onto a common-anode 4-digit display,
// snapshotting the digits once per frame and blinking the colon dot.
module seven_seg_scanner
   import clock_display_pkg::*;
#(
   parameter int SCAN_DIV        = 100_000,
   parameter int GUARD           = 16,
   parameter int BLINK_DIV       = 50_000_000,
   parameter int BLANK_LEAD_ZERO = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [2:0] m1,
   input  logic [3:0] m2,
   input  logic [2:0] s1,
   input  logic [3:0] s2,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [SW-1:0] scan_cnt;
   logic [1:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          phase;
   logic [2:0]    snap_m1;
   logic [3:0]    snap_m2;
   logic [2:0]    snap_s1;
   logic [3:0]    snap_s2;

   logic          scan_wrap;
   logic [3:0]    digit;
   logic [6:0]    dec_seg;
   logic [3:0]    an_d;
   logic [6:0]    seg_d;
   logic          dp_d;

   assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

   // Digits are captured only as the scan returns to slot 0, so a frame never tears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt  <= '0;
         idx       <= IDX_S2;
         blink_cnt <= '0;
         phase     <= 1'b0;
         snap_m1   <= '0;
         snap_m2   <= '0;
         snap_s1   <= '0;
         snap_s2   <= '0;
      end else begin
         if (scan_wrap) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
            if (idx == IDX_M1) begin
               snap_m1 <= m1;
               snap_m2 <= m2;
               snap_s1 <= s1;
               snap_s2 <= s2;
            end
         end else begin
            scan_cnt <= scan_cnt + SW'(1);
         end
         if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   always_comb begin
      digit = snap_s2;
      case (idx)
         IDX_S2:  digit = snap_s2;
         IDX_S1:  digit = {1'b0, snap_s1};
         IDX_M2:  digit = snap_m2;
         IDX_M1:  digit = {1'b0, snap_m1};
         default: digit = snap_s2;
      endcase
   end

   bcd_to_seg u_dec (
      .digit (digit),
      .seg   (dec_seg)
   );

   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (en && (scan_cnt >= SW'(GUARD))) begin
         an_d  = ~(4'b0001 << idx);
         seg_d = dec_seg;
         if ((BLANK_LEAD_ZERO != 0) && (idx == IDX_M1) && (snap_m1 == 3'd0))
            an_d = AN_OFF;
         // Colon lives on the minutes-units digit.
         if ((idx == IDX_M2) && phase)
            dp_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an  <= AN_OFF;
         seg <= SEG_OFF;
         dp  <= 1'b1;
      end else begin
         an  <= an_d;
         seg <= seg_d;
         dp  <= dp_d;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: two instances (leading-zero blanking on/off)
// share stimulus; expected outputs are queued at each edge and popped by a monitor.
module tb_seven_seg_scanner;

   logic       clk;
   logic       reset;
   logic       en;
   logic [2:0] m1;
   logic [3:0] m2;
   logic [2:0] s1;
   logic [3:0] s2;
   logic [3:0] an_a, an_b;
   logic [6:0] seg_a, seg_b;
   logic       dp_a, dp_b;

   int total = 0;
   int bad   = 0;

   logic [23:0] exp_q[$];

   // Hand table of active-low codes; entries 10..15 are the dash.
   logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

   // Reference state: slot counter, digit slot, blink counter/phase, frame snapshot.
   int         m_cnt, m_idx, m_bc;
   bit         m_ph;
   logic [3:0] sn [4];

   seven_seg_scanner #(.SCAN_DIV(4), .GUARD(1), .BLINK_DIV(16), .BLANK_LEAD_ZERO(1)) dut_a (
      .clk(clk), .reset(reset), .en(en), .m1(m1), .m2(m2), .s1(s1), .s2(s2),
      .an(an_a), .seg(seg_a), .dp(dp_a)
   );

   seven_seg_scanner #(.SCAN_DIV(4), .GUARD(1), .BLINK_DIV(16), .BLANK_LEAD_ZERO(0)) dut_b (
      .clk(clk), .reset(reset), .en(en), .m1(m1), .m2(m2), .s1(s1), .s2(s2),
      .an(an_b), .seg(seg_b), .dp(dp_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t actual an/seg/dp=%h/%h/%b expected=%h/%h/%b",
                  name, $time, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
      end
   endtask

   function automatic logic [11:0] model_out(input bit blz);
      logic [3:0] a;
      if (m_cnt < 1 || !en) return {4'hF, 7'h7F, 1'b1};
      a = 4'b0001 << m_idx;
      a = ~a;
      if (blz && m_idx == 3 && sn[3] == 4'd0) a = 4'hF;
      return {a, dec_tab[sn[m_idx]], !(m_idx == 2 && m_ph)};
   endfunction

   // expected-value producer: output after this edge reflects state before it
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt = 0; m_idx = 0; m_bc = 0; m_ph = 1'b0;
         for (int i = 0; i < 4; i++) sn[i] = 4'd0;
      end else begin
         exp_q.push_back({model_out(1'b1), model_out(1'b0)});
         if (m_cnt == 3) begin
            m_cnt = 0;
            if (m_idx == 3) begin
               sn[0] = s2; sn[1] = {1'b0, s1}; sn[2] = m2; sn[3] = {1'b0, m1};
            end
            m_idx = (m_idx + 1) % 4;
         end else begin
            m_cnt++;
         end
         if (m_bc == 15) begin
            m_bc = 0;
            m_ph = ~m_ph;
         end else begin
            m_bc++;
         end
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [23:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("blz1_out", {an_a, seg_a, dp_a}, e[23:12]);
         check("blz0_out", {an_b, seg_b, dp_b}, e[11:0]);
      end
   end

   task automatic set_digits(input logic [2:0] vm1, input logic [3:0] vm2,
                             input logic [2:0] vs1, input logic [3:0] vs2);
      m1 = vm1; m2 = vm2; s1 = vs1; s2 = vs2;
   endtask

   // driver
   initial begin
      bit seen;
      reset = 1'b1;
      en    = 1'b1;
      set_digits(3'd1, 4'd2, 3'd3, 4'd4);
      #1;
      check("reset_a", {an_a, seg_a, dp_a}, {4'hF, 7'h7F, 1'b1});
      check("reset_b", {an_b, seg_b, dp_b}, {4'hF, 7'h7F, 1'b1});
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", {an_a, seg_a, dp_a}, {4'hF, 7'h7F, 1'b1});
      @(negedge clk);
      reset = 1'b0;

      // reach a mid-slot active cycle, then reset with no clock edge
      repeat (6) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("async_reset_a", {an_a, seg_a, dp_a}, {4'hF, 7'h7F, 1'b1});
      check("async_reset_b", {an_b, seg_b, dp_b}, {4'hF, 7'h7F, 1'b1});
      @(negedge clk);
      reset = 1'b0;

      // frame 0 shows zeros, frame 1 shows 1 2 : 3 4 with colon on
      repeat (32) @(negedge clk);

      // leading zero blanking
      set_digits(3'd0, 4'd7, 3'd5, 4'd9);
      repeat (40) @(negedge clk);

      // out-of-range digits decode to dash
      set_digits(3'd1, 4'd0, 3'd7, 4'd12);
      repeat (36) @(negedge clk);

      // change s2 mid-frame (idx2 active); only the next frame may show it
      set_digits(3'd2, 4'd5, 3'd3, 4'd4);
      repeat (32) @(negedge clk);
      seen = 1'b0;
      for (int i = 0; i < 24 && !seen; i++) begin
         @(negedge clk);
         if (an_a == 4'hB) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL wait_idx2 actual an=%h required an=b within 24 cycles", an_a);
      end
      s2 = 4'd8;
      repeat (40) @(negedge clk);

      // disable mid-frame, then resume without reset
      repeat (5) @(negedge clk);
      en = 1'b0;
      repeat (11) @(negedge clk);
      en = 1'b1;
      repeat (36) @(negedge clk);

      repeat (2) @(negedge clk);
      total++;
      if (exp_q.size() > 1) begin
         bad++;
         $display("FAIL drain actual=%0d pending required<=1", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
